// File: rtl/aq_djpeg_pix_pkg.sv
// Shared format codes, luma coefficients, FSM encoding and pixel helpers
// for the aq_djpeg pixel writer.
package aq_djpeg_pix_pkg;

    localparam logic [1:0] FMT_XRGB8888 = 2'd0;
    localparam logic [1:0] FMT_RGB565   = 2'd1;
    localparam logic [1:0] FMT_Y8       = 2'd2;

    localparam logic [7:0] LUMA_R = 8'd77;
    localparam logic [7:0] LUMA_G = 8'd150;
    localparam logic [7:0] LUMA_B = 8'd29;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [7:0] luma(input logic [7:0] r,
                                        input logic [7:0] g,
                                        input logic [7:0] b);
        logic [16:0] acc;
        acc = 17'(LUMA_R) * 17'(r) + 17'(LUMA_G) * 17'(g) + 17'(LUMA_B) * 17'(b);
        return 8'(acc >> 8);
    endfunction

    function automatic logic [15:0] rgb565(input logic [7:0] r,
                                           input logic [7:0] g,
                                           input logic [7:0] b);
        return {r[7:3], g[7:2], b[7:3]};
    endfunction

endpackage

// File: rtl/aq_djpeg_pix_fifo.sv
// Synchronous first-word-fall-through FIFO; the head is visible on dout while
// not empty and reads as zero when empty.
module aq_djpeg_pix_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign full    = (count == (AW+1)'(DEPTH)) && !do_pop;
    assign do_push = push && !full;
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/aq_djpeg_pix_writer.sv
// Converts the decoder's MCU-order pixel stream into byte-addressed memory
// writes in XRGB8888 / RGB565 / Y8, buffered behind a valid/ready FIFO.
module aq_djpeg_pix_writer
    import aq_djpeg_pix_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [1:0]        cfg_fmt,
    input  logic              pix_en,
    input  logic [15:0]       pix_width,
    input  logic [15:0]       pix_height,
    input  logic [15:0]       pix_x,
    input  logic [15:0]       pix_y,
    input  logic [7:0]        pix_r,
    input  logic [7:0]        pix_g,
    input  logic [7:0]        pix_b,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [3:0]        wr_strb,
    output logic              busy,
    output logic              frame_done,
    output logic              overflow,
    output logic [31:0]       pix_count,
    output logic [31:0]       checksum
);

    localparam int unsigned FW = ADDR_W + 32 + 4;

    state_t state, state_next;

    logic              keep;
    logic              load_target;
    logic [31:0]       target;

    logic              s1_valid;
    logic [31:0]       s1_index;
    logic [7:0]        s1_r, s1_g, s1_b;

    logic [ADDR_W-1:0] pk_off;
    logic [ADDR_W-1:0] pk_addr;
    logic [31:0]       pk_data;
    logic [3:0]        pk_strb;
    logic [15:0]       pk_565;
    logic [7:0]        pk_y;

    logic              s2_valid;
    logic [ADDR_W-1:0] s2_addr;
    logic [31:0]       s2_data;
    logic [3:0]        s2_strb;
    logic [23:0]       s2_rgb;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FW-1:0]     fifo_dout;

    assign keep = pix_en && (pix_x < pix_width) && (pix_y < pix_height);

    // Stage 1: range filter and linear pixel index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_index <= '0;
            s1_r     <= '0;
            s1_g     <= '0;
            s1_b     <= '0;
        end else begin
            s1_valid <= keep;
            if (keep) begin
                s1_index <= 32'(pix_y) * 32'(pix_width) + 32'(pix_x);
                s1_r     <= pix_r;
                s1_g     <= pix_g;
                s1_b     <= pix_b;
            end
        end
    end

    always_comb begin
        pk_565  = rgb565(s1_r, s1_g, s1_b);
        pk_y    = luma(s1_r, s1_g, s1_b);
        pk_off  = ADDR_W'(s1_index) << 2;
        pk_data = {8'h00, s1_r, s1_g, s1_b};
        pk_strb = 4'hF;
        case (cfg_fmt)
            FMT_RGB565: pk_off = ADDR_W'(s1_index) << 1;
            FMT_Y8:     pk_off = ADDR_W'(s1_index);
            default:    pk_off = ADDR_W'(s1_index) << 2;
        endcase
        pk_addr = cfg_base + pk_off;
        case (cfg_fmt)
            FMT_RGB565: begin
                pk_data = {pk_565, pk_565};
                pk_strb = pk_addr[1] ? 4'b1100 : 4'b0011;
            end
            FMT_Y8: begin
                pk_data = {4{pk_y}};
                pk_strb = 4'b0001 << pk_addr[1:0];
            end
            default: begin
                pk_data = {8'h00, s1_r, s1_g, s1_b};
                pk_strb = 4'hF;
            end
        endcase
    end

    // Stage 2: packed write ready for the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_addr  <= '0;
            s2_data  <= '0;
            s2_strb  <= '0;
            s2_rgb   <= '0;
        end else begin
            s2_valid <= s1_valid && !frame_start;
            if (s1_valid) begin
                s2_addr <= pk_addr;
                s2_data <= pk_data;
                s2_strb <= pk_strb;
                s2_rgb  <= {s1_r, s1_g, s1_b};
            end
        end
    end

    assign fifo_push = s2_valid && !frame_start;
    assign fifo_pop  = wr_ready && !fifo_empty;

    aq_djpeg_pix_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (frame_start),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   ({s2_addr, s2_data, s2_strb}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign wr_valid = !fifo_empty;
    assign {wr_addr, wr_data, wr_strb} = fifo_dout;
    assign busy = (state == ST_RUN) || !fifo_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_count <= '0;
            checksum  <= '0;
            overflow  <= 1'b0;
        end else if (frame_start) begin
            pix_count <= '0;
            checksum  <= '0;
            overflow  <= 1'b0;
        end else begin
            if (fifo_pop) pix_count <= pix_count + 1'b1;
            if (fifo_push && !fifo_full) checksum <= checksum + {8'h00, s2_rgb};
            if (fifo_push && fifo_full)  overflow <= 1'b1;
        end
    end

    // A pixel captured alongside frame_start opens the new frame immediately.
    always_comb begin
        state_next  = state;
        frame_done  = 1'b0;
        load_target = 1'b0;
        if (frame_start) begin
            state_next  = keep ? ST_RUN : ST_IDLE;
            load_target = keep;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (keep) begin
                        state_next  = ST_RUN;
                        load_target = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (pix_count == target && fifo_empty) begin
                        state_next = ST_DONE;
                        frame_done = 1'b1;
                    end
                end
                default: state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            target <= '0;
        end else begin
            state <= state_next;
            if (load_target) target <= 32'(pix_width) * 32'(pix_height);
        end
    end

endmodule
